dcache_wt: RTL and testbench

//   Direct-mapped, write-through, no-write-allocate data cache between the stage-3 data memory

---
 rtl/dcache_if.sv | 27 ++
 rtl/dcache_wt.sv | 97 +++++++++
 tb/tb_dcache_wt.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_if.sv
// dcache_if: pipeline-side request/response and 128-bit memory request/response bundle
interface dcache_if;
  logic cpu_req_valid;
  logic [31:0] cpu_req_addr;
  logic [31:0] cpu_req_data;
  logic [3:0] cpu_req_write;
  logic cpu_req_ready;
  logic cpu_resp_valid;
  logic [31:0] cpu_resp_data;
  logic stall;
  logic mem_req_valid;
  logic mem_req_ready;
  logic mem_req_rw;
  logic [27:0] mem_req_addr;
  logic [127:0] mem_req_data;
  logic [15:0] mem_req_mask;
  logic mem_resp_valid;
  logic [127:0] mem_resp_data;
  modport slave(
    input cpu_req_valid, cpu_req_addr, cpu_req_data, cpu_req_write, mem_req_ready, mem_resp_valid, mem_resp_data,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data, stall, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask
  );
  modport master(
    output cpu_req_valid, cpu_req_addr, cpu_req_data, cpu_req_write, mem_req_ready, mem_resp_valid, mem_resp_data,
    input cpu_req_ready, cpu_resp_valid, cpu_resp_data, stall, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask
  );
endinterface

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped write-through no-write-allocate data cache with 4-word lines
module dcache_wt #(
  parameter int LINES = 16,
  parameter int LINE_BITS = 128
) (
  input logic clk,
  input logic reset,
  dcache_if.slave bus
);
  localparam int IB = $clog2(LINES);
  localparam int TW = 28 - IB;
  typedef enum logic [2:0] {IDLE, MREQ, MWAIT, RESP, WREQ} state_t;
  state_t st;
  logic [LINE_BITS-1:0] data_q [LINES];
  logic [TW-1:0] tag_q [LINES];
  logic [LINES-1:0] valid_q;
  logic [IB-1:0] idx, req_idx;
  logic [TW-1:0] tag, req_tag;
  logic [1:0] word, req_word;
  logic hit, acc, store;
  logic [15:0] wmask;
  logic [LINE_BITS-1:0] wdata;
  assign idx = bus.cpu_req_addr[3+IB:4];
  assign tag = bus.cpu_req_addr[31:4+IB];
  assign word = bus.cpu_req_addr[3:2];
  assign hit = valid_q[idx] && tag_q[idx] == tag;
  assign acc = bus.cpu_req_valid && bus.cpu_req_ready;
  assign store = |bus.cpu_req_write;
  assign wmask = 16'(bus.cpu_req_write) << {word, 2'b00};
  assign wdata = {4{bus.cpu_req_data}};
  assign bus.stall = !bus.cpu_req_ready || (acc && (store || !hit));
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      valid_q <= '0;
      bus.cpu_req_ready <= 1'b1;
      bus.cpu_resp_valid <= 1'b0;
      bus.cpu_resp_data <= '0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_rw <= 1'b0;
      bus.mem_req_addr <= '0;
      bus.mem_req_data <= '0;
      bus.mem_req_mask <= '0;
    end else begin
      bus.cpu_resp_valid <= 1'b0;
      case (st)
        IDLE: if (acc) begin
          req_idx <= idx;
          req_tag <= tag;
          req_word <= word;
          for (int b = 0; b < 16; b++)
            if (store && hit && wmask[b]) data_q[idx][8*b +: 8] <= wdata[8*b +: 8];
          if (!store && hit) begin
            bus.cpu_resp_valid <= 1'b1;
            bus.cpu_resp_data <= data_q[idx][{word, 5'b0} +: 32];
          end
          // wmask is zero for loads, so read requests carry an empty mask
          if (store || !hit) begin
            st <= store ? WREQ : MREQ;
            bus.cpu_req_ready <= 1'b0;
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_rw <= store;
            bus.mem_req_addr <= bus.cpu_req_addr[31:4];
            bus.mem_req_data <= wdata;
            bus.mem_req_mask <= wmask;
          end
        end
        MREQ: if (bus.mem_req_ready) begin
          st <= MWAIT;
          bus.mem_req_valid <= 1'b0;
        end
        MWAIT: if (bus.mem_resp_valid) begin
          st <= RESP;
          data_q[req_idx] <= bus.mem_resp_data;
          tag_q[req_idx] <= req_tag;
          valid_q[req_idx] <= 1'b1;
          bus.cpu_resp_valid <= 1'b1;
          bus.cpu_resp_data <= bus.mem_resp_data[{req_word, 5'b0} +: 32];
        end
        RESP: begin
          st <= IDLE;
          bus.cpu_req_ready <= 1'b1;
        end
        WREQ: if (bus.mem_req_ready) begin
          st <= IDLE;
          bus.cpu_req_ready <= 1'b1;
          bus.mem_req_valid <= 1'b0;
        end
        default: begin
          st <= IDLE;
          bus.cpu_req_ready <= 1'b1;
          bus.mem_req_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: table-driven load/store vectors with a load-response scoreboard and a word-level memory model
module tb_dcache_wt;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  dcache_if bus();
  dcache_wt #(.LINES(16), .LINE_BITS(128)) dut(.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [31:0] addr;
    logic [3:0] we;
    logic [31:0] data;
    bit miss;
  } req_t;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'h0;
  logic [31:0] mem_w [logic [31:0]];
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] k = {a[31:2], 2'b00};
    return mem_w.exists(k) ? mem_w[k] : (k ^ 32'hC0DE0000);
  endfunction
  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = mem_word({a[31:4], 4'h0} + 32'(4 * w));
    return l;
  endfunction
  always @(negedge clk) begin
    if (!reset && bus.cpu_resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%0h expected=none t=%0t", bus.cpu_resp_data, $time);
      end else begin
        last_exp = exp_q.pop_front();
        chk("resp_data", bus.cpu_resp_data, last_exp);
      end
    end
  end
  task automatic wait_ready();
    int n = 0;
    while (!bus.cpu_req_ready && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("ready_return", bus.cpu_req_ready, 1);
    chk("stall_idle", bus.stall, 0);
  endtask
  task automatic do_req(input req_t r);
    bit st = |r.we;
    logic [15:0] m = st ? (16'(r.we) << (4 * r.addr[3:2])) : 16'h0;
    logic [31:0] w;
    int lat;
    @(negedge clk);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr = r.addr;
    bus.cpu_req_data = r.data;
    bus.cpu_req_write = r.we;
    #1;
    chk("ready_accept", bus.cpu_req_ready, 1);
    chk("stall_accept", bus.stall, st | r.miss);
    if (!st && !r.miss) exp_q.push_back(mem_word(r.addr));
    @(posedge clk);
    #1;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_write = 4'h0;
    if (!st && !r.miss) begin
      chk("hit_no_mem_req", bus.mem_req_valid, 0);
      return;
    end
    chk("mem_req_valid", bus.mem_req_valid, 1);
    chk("mem_req_rw", bus.mem_req_rw, st);
    chk("mem_req_addr", bus.mem_req_addr, r.addr[31:4]);
    chk("mem_req_mask", bus.mem_req_mask, m);
    if (st) chk("mem_req_data", bus.mem_req_data, {4{r.data}});
    lat = $urandom_range(0, 2);
    repeat (lat) begin
      @(negedge clk);
      chk("mem_req_hold", {bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_mask}, {1'b1, r.addr[31:4], m});
    end
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b0;
    if (st) begin
      w = mem_word(r.addr);
      for (int b = 0; b < 4; b++) if (r.we[b]) w[8*b +: 8] = r.data[8*b +: 8];
      mem_w[{r.addr[31:2], 2'b00}] = w;
    end else begin
      exp_q.push_back(mem_word(r.addr));
      @(negedge clk);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data = line_of(r.addr);
      @(posedge clk);
      #1;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data = '0;
    end
    wait_ready();
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
  initial begin
    req_t tv[15];
    tv = '{
      '{32'h0000_1004, 4'h0, 32'h0, 1'b1},
      '{32'h0000_1004, 4'h0, 32'h0, 1'b0},
      '{32'h0000_1008, 4'h0, 32'h0, 1'b0},
      '{32'h0000_1006, 4'hC, 32'hABCD_0000, 1'b0},
      '{32'h0000_1004, 4'h0, 32'h0, 1'b0},
      '{32'h0000_2000, 4'hF, 32'h1234_5678, 1'b0},
      '{32'h0000_2000, 4'h0, 32'h0, 1'b1},
      '{32'h0000_1004, 4'h0, 32'h0, 1'b1},
      '{32'h0000_1104, 4'h0, 32'h0, 1'b1},
      '{32'h0000_1004, 4'h0, 32'h0, 1'b1},
      '{32'h0000_100C, 4'h0, 32'h0, 1'b0},
      '{32'h0000_1010, 4'h3, 32'h0000_5555, 1'b0},
      '{32'h0000_1010, 4'h0, 32'h0, 1'b1},
      '{32'h0000_1012, 4'hC, 32'h7777_0000, 1'b0},
      '{32'h0000_1010, 4'h0, 32'h0, 1'b0}
    };
    mem_w[32'h0000_1004] = 32'hDEAD_BEEF;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_addr = '0;
    bus.cpu_req_data = '0;
    bus.cpu_req_write = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_ready", bus.cpu_req_ready, 1);
    chk("rst_resp_valid", bus.cpu_resp_valid, 0);
    chk("rst_resp_data", bus.cpu_resp_data, 0);
    chk("rst_mem_req", {bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr, bus.mem_req_mask}, 0);
    chk("rst_stall", bus.stall, 0);
    for (int i = 0; i < 15; i++) do_req(tv[i]);
    repeat (2) @(negedge clk);
    chk("resp_data_hold", bus.cpu_resp_data, last_exp);
    @(negedge clk);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr = 32'h0000_3008;
    @(posedge clk);
    #1;
    bus.cpu_req_valid = 1'b0;
    chk("mid_miss_req", bus.mem_req_valid, 1);
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b0;
    chk("mwait_stall", bus.stall, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_ready", bus.cpu_req_ready, 1);
    chk("mid_rst_mem_req", bus.mem_req_valid, 0);
    @(negedge clk);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = line_of(32'h0000_3008);
    @(posedge clk);
    #1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = '0;
    @(negedge clk);
    chk("stray_resp_ignored", bus.cpu_resp_valid, 0);
    chk("stray_resp_ready", bus.cpu_req_ready, 1);
    do_req('{32'h0000_3008, 4'h0, 32'h0, 1'b1});
    do_req('{32'h0000_1004, 4'h0, 32'h0, 1'b1});
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
